// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver (8N1) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive an even-parity bit between the data and stop bits.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW  = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic            rxs_prev_q, rxs_prev_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic            rxs, tick, sample, push, pop, full, empty, accept;
`ifdef UART_RX_PARITY_EN
  logic            parity_err_q, parity_err_d;
`endif

  assign rxs    = sync_q[1];
  assign tick   = div_q == DW'(DIV - 1);
  assign sample = tick && tick_cnt_q == 4'd15;

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rxd};
    rxs_prev_d  = rxs;
    div_d       = tick ? '0 : div_q + DW'(1);
    tick_cnt_d  = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (rxs_prev_q && !rxs) begin
        state_d    = START;
        div_d      = '0;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        par_bad_d  = 1'b0;
      end
      START: if (tick && tick_cnt_q == 4'd7) begin
        state_d    = rxs ? IDLE : DATA;
        tick_cnt_d = '0;
      end
      DATA: if (sample) begin
        shift_d   = {rxs, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
        if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (sample) begin
        par_bad_d    = rxs != ^shift_q;
        parity_err_d = par_bad_d;
        state_d      = STOP;
      end
`endif
      STOP: if (sample) begin
        state_d     = IDLE;
        push        = rxs && !par_bad_q;
        frame_err_d = !rxs;
      end
      default: state_d = IDLE;
    endcase
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = wr_ptr_q == rd_ptr_q;
  assign full   = wr_ptr_q[AW] != rd_ptr_q[AW] && wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0];
  assign pop    = rd_en && !empty;
  assign accept = push && (!full || pop);

  always_comb begin
    mem_d     = mem_q;
    overrun_d = push && full && !pop;
    wr_ptr_d  = wr_ptr_q + PW'(accept);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    if (accept) mem_d[wr_ptr_q[AW-1:0]] = shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      rxs_prev_q  <= 1'b1;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rxs_prev_q  <= rxs_prev_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) parity_err_q <= rst_n ? parity_err_d : 1'b0;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rd_valid  = !empty;
  assign rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 32 MHz / 1 Mbaud (32 clocks per bit).
module tb_uart_rx_fifo;
  localparam int BIT = 32;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rd_en = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, frame_err, overrun, parity_err, busy;
  int n_cmp = 0, n_err = 0, cyc = 0, rise_cyc = -1, start_cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, pop_cnt = 0;
  int lat, f0, o0, p0, c0;
  logic seen;
  logic rv_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.CLK_FREQ(32000000), .BAUD(1000000), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: pulse counting and pop checking against the scoreboard queue.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_err) pe_cnt++;
    if (rd_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = rd_valid;
    if (rd_en && rd_valid) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par);
    rxd = 1'b0;
    start_cyc = cyc;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      step(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    step(BIT);
`else
    if (par === 1'bx) rxd = 1'b1;
`endif
    rxd = stop;
    step(BIT);
    rxd = 1'b1;
    step(BIT);
  endtask

  task automatic send_ok(input logic [7:0] d);
    exp_q.push_back(d);
    send(d, 1'b1, ^d);
  endtask

  task automatic drain();
    rd_en = 1'b1;
    for (int i = 0; i < 40 && rd_valid; i++) step(1);
    rd_en = 1'b0;
    step(1);
    chk("drain_rd_valid", rd_valid, 0);
    chk("drain_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(4);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    step(4);

    f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
    rise_cyc = -1;
    send_ok(8'hA5);
    lat = rise_cyc - start_cyc;
    chk_range("a5_latency", lat, NB * BIT - 16, NB * BIT - 10);
    chk("a5_frame_err", fe_cnt - f0, 0);
    chk("a5_overrun", ov_cnt - o0, 0);
    chk("a5_parity_err", pe_cnt - p0, 0);
    chk("a5_rd_valid", rd_valid, 1);
    drain();
    if (lat < 2 || lat > 400) lat = NB * BIT - 13;

    seen = 1'b0;
    rxd = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 8) rxd = 1'b1;
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", seen, 1);
    chk("glitch_busy_20", busy, 0);
    step(64);
    chk("glitch_no_push", rd_valid, 0);

    f0 = fe_cnt;
    send(8'h3C, 1'b0, ^8'h3C);
    chk("3c_frame_err_cycles", fe_cnt - f0, 1);
    chk("3c_rd_valid", rd_valid, 0);

    f0 = fe_cnt;
    rxd = 1'b0;
    step(600);
    rxd = 1'b1;
    step(64);
    chk("break_frame_err_cycles", fe_cnt - f0, 1);
    chk("break_busy", busy, 0);
    chk("break_rd_valid", rd_valid, 0);

    o0 = ov_cnt; c0 = pop_cnt;
    for (int d = 1; d <= 8; d++) send_ok(8'(d));
    chk("ovr_before_9th", ov_cnt - o0, 0);
    send(8'h09, 1'b1, ^8'h09);
    chk("ovr_on_9th", ov_cnt - o0, 1);
    chk("ovr_rd_valid", rd_valid, 1);
    drain();
    chk("ovr_pop_count", pop_cnt - c0, 8);

    for (int d = 1; d <= 8; d++) send_ok(8'(d));
    exp_q.push_back(8'h09);
    o0 = ov_cnt; c0 = pop_cnt;
    fork
      send(8'h09, 1'b1, ^8'h09);
      begin
        step(lat - 1);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
      end
    join
    chk("same_cycle_overrun", ov_cnt - o0, 0);
    drain();
    chk("same_cycle_pop_count", pop_cnt - c0, 9);

    f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
    rxd = 1'b0;
    step(100);
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    step(2);
    chk("midrst_busy_in_reset", busy, 0);
    rst_n = 1'b1;
    rxd = 1'b1;
    step(400);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_errs", (fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0), 0);
    chk("midrst_busy_after", busy, 0);

`ifdef UART_RX_PARITY_EN
    p0 = pe_cnt;
    send(8'h07, 1'b1, 1'b0);
    chk("par_bad_pulse", pe_cnt - p0, 1);
    chk("par_bad_no_push", rd_valid, 0);
    send_ok(8'h07);
    chk("par_good_no_pulse", pe_cnt - p0, 1);
    chk("par_good_rd_valid", rd_valid, 1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, giving the system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, giving the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, giving receive FIFO entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-006 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port rd_en, input, 1 bit: pop request from the CPU side.
REQ-008 SHALL have port rd_data, output, 8 bits: FIFO head byte, valid while rd_valid=1.
REQ-009 SHALL have port rd_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer; the synchronized value is called rxs.
REQ-015 SHALL generate an oversample tick every DIV=CLK_FREQ/(BAUD*16) clocks, using integer division; DIV<2 is illegal.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE SHALL go to START when rxs falls from 1 to 0, clearing the tick and sample counters in that cycle.
REQ-018 START SHALL sample rxs at tick 8; if rxs=1 (glitch), go to IDLE with no output; otherwise go to DATA and restart the 16-tick count.
REQ-019 DATA SHALL sample rxs at every 16th tick, giving 8 bits LSB first, then go to PARITY (macro on) or STOP (macro off).
REQ-020 STOP SHALL sample rxs at its 16th tick: if 1, push the byte; if 0, pulse frame_err, discard the byte, and push nothing.
REQ-021 After the STOP sample the FSM SHALL enter IDLE in the next cycle; a line held low (break) SHALL NOT restart reception until rxs has gone high and then fallen again.
REQ-022 A pushed byte SHALL appear at rd_data with rd_valid=1 exactly one clock after the STOP sample cycle (first-word-fall-through).
REQ-023 The FIFO SHALL pop when rd_en=1 and rd_valid=1; rd_en while empty SHALL be ignored.
REQ-024 A push when full with no pop in the same cycle SHALL drop the new byte, pulse overrun, and leave the FIFO contents unchanged.
REQ-025 When push and pop occur in the same cycle while full, the push SHALL be accepted and overrun SHALL stay 0; when they occur while empty, the byte SHALL be stored and rd_valid SHALL rise on the next cycle.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with one extra pointer bit.

Reset
REQ-027 While rst_n=0 at a clk edge: FSM=IDLE, counters=0, synchronizer flops=1, FIFO empty, rd_valid=0, rd_data=0, frame_err=overrun=parity_err=busy=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no push and no error pulse.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit after the data bits. On a mismatch it SHALL pulse parity_err and discard the byte, but still check the stop bit.
REQ-030 With UART_RX_PARITY_EN undefined, the frame SHALL be 8N1, the PARITY state SHALL be unreachable, and parity_err SHALL be tied to 0.

Verification (CLK_FREQ=32000000, BAUD=1000000, so DIV=2 and 1 bit=32 clocks)
REQ-031 Send 0xA5 as 8N1 -> rd_valid rises 1 clock after the stop-bit mid-sample; rd_data=0xA5; no error pulses.
REQ-032 Low pulse of 8 clocks on idle rxd -> returns to IDLE; busy low again at most 20 clocks after the edge; no push.
REQ-033 Send 0x3C with stop bit=0 -> frame_err pulses exactly 1 cycle; FIFO stays empty.
REQ-034 Send 9 bytes 0x01..0x09 with rd_en=0 -> one overrun pulse on the 9th byte; popping 8 times yields 0x01..0x08 in order, then rd_valid=0.
REQ-035 With FIFO full, assert rd_en in the same cycle as the 9th push -> no overrun; subsequent pops yield 0x02..0x09.
REQ-036 With UART_RX_PARITY_EN defined, send 0x07 with parity bit=0 -> parity_err pulses once and no push; 0x07 with parity bit=1 -> byte received.
